// File: rtl/axi4_lite_write_arbiter_pkg.sv
// Shared types for the AXI4-Lite write arbiter: response codes, FSM states
// and an index-width helper used by the arbiter and its round-robin core.
package axi4_lite_write_arbiter_pkg;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    RESP = 2'b10
  } state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// Combinational round-robin grant: picks the first valid requester at or
// after the pointer, wrapping modulo NUM_REQ. The pointer lives in the parent.
module axi4_lite_rr_arbiter
  import axi4_lite_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   grant_idx
);

  int idx;

  // Scan requesters starting at the pointer and keep the first one found.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_write_arbiter.sv
// Shares one AXI4-Lite write master port between NUM_REQ requesters with
// round-robin arbitration and a single outstanding write.
// Optional feature macro: AXI4LITE_WR_ADDR_CHECK_EN (out-of-range addresses
// are answered locally with DECERR and never reach the bus).
module axi4_lite_write_arbiter
  import axi4_lite_write_arbiter_pkg::*;
#(
  parameter int                       NUM_REQ       = 2,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = '1
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
  input  logic [NUM_REQ*3-1:0]              req_prot,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [1:0]                        rsp_bresp,
  output logic [ADDRESS_WIDTH-1:0]          awaddr,
  output logic [2:0]                        awprot,
  output logic                              awvalid,
  input  logic                              awready,
  output logic [DATA_WIDTH-1:0]             wdata,
  output logic [DATA_WIDTH/8-1:0]           wstrb,
  output logic                              wvalid,
  input  logic                              wready,
  input  logic [1:0]                        bresp,
  input  logic                              bvalid,
  output logic                              bready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = idx_width(NUM_REQ);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
    logic [STRB_WIDTH-1:0]    strb;
    logic [2:0]               prot;
  } req_t;

  state_e               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     ptr_next;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     grant_q;
  logic                 grant_valid;
  req_t                 req_sel;
  req_t                 req_q;
  logic                 aw_pend;
  logic                 w_pend;
  logic                 decerr_q;
  logic                 addr_err;
  logic [NUM_REQ-1:0]   grant_onehot;
  logic [NUM_REQ-1:0]   owner_onehot;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic [1:0]           rsp_bresp_q;

  axi4_lite_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_valid   (req_valid),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Select the winning requester's payload and build one-hot views of the
  // new grant and of the requester that owns the transfer in flight.
  always_comb begin
    req_sel      = '0;
    grant_onehot = '0;
    owner_onehot = '0;
    ptr_next     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == grant_idx) begin
        req_sel.addr    = req_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        req_sel.data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_sel.strb    = req_strb[i*STRB_WIDTH +: STRB_WIDTH];
        req_sel.prot    = req_prot[i*3 +: 3];
        grant_onehot[i] = 1'b1;
      end
      if (PTR_W'(i) == grant_q) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

`ifdef AXI4LITE_WR_ADDR_CHECK_EN
  assign addr_err = (req_sel.addr < MIN_ADDRESS) || (req_sel.addr > MAX_ADDRESS);
`else
  logic unused_range;
  assign addr_err     = 1'b0;
  assign unused_range = ^{MIN_ADDRESS, MAX_ADDRESS};
`endif

  // Main sequencer: grant in IDLE, run AW/W independently in XFER, forward
  // the write response in RESP. Everything is registered so outputs clear
  // the moment reset asserts.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_q     <= '0;
      req_q       <= '0;
      aw_pend     <= 1'b0;
      w_pend      <= 1'b0;
      decerr_q    <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_bresp_q <= 2'b00;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant_q     <= grant_idx;
            req_q       <= req_sel;
            req_ready_q <= grant_onehot;
            ptr         <= ptr_next;
            decerr_q    <= addr_err;
            aw_pend     <= !addr_err;
            w_pend      <= !addr_err;
            state       <= addr_err ? RESP : XFER;
          end
        end
        XFER: begin
          if (aw_pend && awready) aw_pend <= 1'b0;
          if (w_pend && wready)   w_pend  <= 1'b0;
          if ((!aw_pend || awready) && (!w_pend || wready)) state <= RESP;
        end
        RESP: begin
          if (decerr_q) begin
            rsp_valid_q <= owner_onehot;
            rsp_bresp_q <= BRESP_DECERR;
            decerr_q    <= 1'b0;
            state       <= IDLE;
          end else if (bvalid) begin
            rsp_valid_q <= owner_onehot;
            rsp_bresp_q <= bresp;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_bresp = rsp_bresp_q;
  assign awaddr    = req_q.addr;
  assign awprot    = req_q.prot;
  assign awvalid   = aw_pend;
  assign wdata     = req_q.data;
  assign wstrb     = req_q.strb;
  assign wvalid    = w_pend;
  assign bready    = (state == RESP) && !decerr_q;

endmodule

// File: tb/tb_axi4_lite_write_arbiter.sv
// Self-checking bench for axi4_lite_write_arbiter: directed steps drive the
// requesters and a scripted slave; a scoreboard of expected grants, AW/W
// payloads and responses is checked as the DUT produces them.
module tb_axi4_lite_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;

  logic                    aclk = 1'b0;
  logic                    aresetn;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*DW-1:0]   req_data;
  logic [NUM_REQ*SW-1:0]   req_strb;
  logic [NUM_REQ*3-1:0]    req_prot;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [1:0]              rsp_bresp;
  logic [AW-1:0]           awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DW-1:0]           wdata;
  logic [SW-1:0]           wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  typedef struct {
    int            req;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
  } wr_t;

  typedef struct {
    int         req;
    logic [1:0] resp;
  } rsp_t;

  int   exp_grant[$];
  wr_t  exp_aw[$];
  wr_t  exp_w[$];
  rsp_t exp_rsp[$];

  int checks = 0;
  int errors = 0;

  axi4_lite_write_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .MIN_ADDRESS   (32'h0000_0000),
    .MAX_ADDRESS   (32'h0000_00FF)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .req_prot  (req_prot),
    .rsp_valid (rsp_valid),
    .rsp_bresp (rsp_bresp),
    .awaddr    (awaddr),
    .awprot    (awprot),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_request(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] strb, input logic [2:0] prot, input bit on_bus);
    wr_t w;
    req_addr[idx*AW +: AW] = addr;
    req_data[idx*DW +: DW] = data;
    req_strb[idx*SW +: SW] = strb;
    req_prot[idx*3 +: 3]   = prot;
    req_valid[idx]         = 1'b1;
    w.req  = idx;
    w.addr = addr;
    w.data = data;
    w.strb = strb;
    w.prot = prot;
    exp_grant.push_back(idx);
    if (on_bus) begin
      exp_aw.push_back(w);
      exp_w.push_back(w);
    end
  endtask

  task automatic wait_ready(input int idx, input bit drop, input logic exp_awvalid);
    bit found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (req_ready[idx]) found = 1'b1;
      else tick();
    end
    if (!found) begin
      check_output("grant_timeout", 64'(req_ready), 64'(1) << idx);
    end else begin
      if (drop) req_valid[idx] = 1'b0;
      check_output("aw_latency", 64'(awvalid), 64'(exp_awvalid));
    end
  endtask

  task automatic slave_xfer(input int aw_dly, input int w_dly, input logic [1:0] resp,
                            input int idx, input logic [DW-1:0] data, input bit stray_b);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs;
    bit w_hs;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      awready = !aw_done && (c >= aw_dly);
      wready  = !w_done && (c >= w_dly);
      bvalid  = stray_b;
      bresp   = 2'b01;
      if (aw_done) check_output("aw_dropped", 64'(awvalid), 64'(0));
      else         check_output("aw_held", 64'(awvalid), 64'(1));
      if (w_done) begin
        check_output("w_dropped", 64'(wvalid), 64'(0));
      end else begin
        check_output("w_held", 64'(wvalid), 64'(1));
        check_output("w_stable", 64'(wdata), 64'(data));
      end
      if (stray_b) check_output("bready_in_xfer", 64'(bready), 64'(0));
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
    end
    if (!(aw_done && w_done)) check_output("xfer_timeout", 64'({aw_done, w_done}), 64'(2'b11));
    awready = 1'b0;
    wready  = 1'b0;
    check_output("aw_idle_in_resp", 64'(awvalid), 64'(0));
    check_output("w_idle_in_resp", 64'(wvalid), 64'(0));
    check_output("bready_in_resp", 64'(bready), 64'(1));
    bvalid = 1'b1;
    bresp  = resp;
    exp_rsp.push_back('{req: idx, resp: resp});
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    check_output("rsp_latency", 64'(rsp_valid), 64'(1) << idx);
    check_output("rsp_code", 64'(rsp_bresp), 64'(resp));
    check_output("bready_after_resp", 64'(bready), 64'(0));
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge aclk) begin
    int   g;
    wr_t  w;
    rsp_t r;
    if (aresetn) begin
      if (|req_ready) begin
        if (exp_grant.size() == 0) check_output("unexpected_grant", 64'(req_ready), 64'(0));
        else begin
          g = exp_grant.pop_front();
          check_output("grant_order", 64'(req_ready), 64'(1) << g);
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) check_output("unexpected_aw", 64'(awaddr), 64'(0) - 1);
        else begin
          w = exp_aw.pop_front();
          check_output("awaddr", 64'(awaddr), 64'(w.addr));
          check_output("awprot", 64'(awprot), 64'(w.prot));
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) check_output("unexpected_w", 64'(wdata), 64'(0) - 1);
        else begin
          w = exp_w.pop_front();
          check_output("wdata", 64'(wdata), 64'(w.data));
          check_output("wstrb", 64'(wstrb), 64'(w.strb));
        end
      end
      if (|rsp_valid) begin
        if (exp_rsp.size() == 0) check_output("unexpected_rsp", 64'(rsp_valid), 64'(0));
        else begin
          r = exp_rsp.pop_front();
          check_output("rsp_owner", 64'(rsp_valid), 64'(1) << r.req);
          check_output("rsp_bresp", 64'(rsp_bresp), 64'(r.resp));
        end
      end
    end
  end

  // Hard stop in case a step ever stalls beyond its own bounds.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of scenarios.
  initial begin
    aresetn   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;
    req_prot  = '0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    repeat (3) @(posedge aclk);
    #1;

    check_output("reset_req_ready", 64'(req_ready), 64'(0));
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check_output("reset_rsp_bresp", 64'(rsp_bresp), 64'(0));
    check_output("reset_awvalid", 64'(awvalid), 64'(0));
    check_output("reset_awaddr", 64'(awaddr), 64'(0));
    check_output("reset_wvalid", 64'(wvalid), 64'(0));
    check_output("reset_wdata", 64'(wdata), 64'(0));
    check_output("reset_bready", 64'(bready), 64'(0));
    aresetn = 1'b1;
    tick();

    $display("[TB] single write");
    apply_request(0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1'b1);
    wait_ready(0, 1'b1, 1'b1);
    slave_xfer(0, 0, 2'b00, 0, 32'hDEADBEEF, 1'b0);
    tick();

    $display("[TB] channel skew with stray bvalid");
    apply_request(1, 32'h24, 32'h12345678, 4'h3, 3'b010, 1'b1);
    wait_ready(1, 1'b1, 1'b1);
    slave_xfer(0, 3, 2'b00, 1, 32'h12345678, 1'b1);
    tick();

    $display("[TB] fairness");
    apply_request(0, 32'h40, 32'hA5A5A5A5, 4'hF, 3'b001, 1'b1);
    apply_request(1, 32'h80, 32'h5A5A5A5A, 4'hC, 3'b100, 1'b1);
    apply_request(0, 32'h40, 32'hA5A5A5A5, 4'hF, 3'b001, 1'b1);
    apply_request(1, 32'h80, 32'h5A5A5A5A, 4'hC, 3'b100, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_ready(k % 2, k >= 2, 1'b1);
      slave_xfer(1, 0, 2'b00, k % 2, (k % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b0);
    end
    tick();

    $display("[TB] slave error");
    apply_request(1, 32'h88, 32'hCAFEF00D, 4'hF, 3'b000, 1'b1);
    wait_ready(1, 1'b1, 1'b1);
    slave_xfer(2, 1, 2'b10, 1, 32'hCAFEF00D, 1'b0);
    tick();

    $display("[TB] mid-transfer reset");
    apply_request(0, 32'h30, 32'h11112222, 4'hF, 3'b000, 1'b1);
    wait_ready(0, 1'b1, 1'b1);
    tick();
    aresetn = 1'b0;
    #1;
    check_output("mid_reset_awvalid", 64'(awvalid), 64'(0));
    check_output("mid_reset_wvalid", 64'(wvalid), 64'(0));
    check_output("mid_reset_awaddr", 64'(awaddr), 64'(0));
    check_output("mid_reset_wdata", 64'(wdata), 64'(0));
    check_output("mid_reset_bready", 64'(bready), 64'(0));
    check_output("mid_reset_rsp", 64'(rsp_valid), 64'(0));
    exp_aw.delete();
    exp_w.delete();
    tick();
    aresetn = 1'b1;
    tick();
    apply_request(0, 32'h34, 32'h33334444, 4'hF, 3'b000, 1'b1);
    apply_request(1, 32'h38, 32'h55556666, 4'h1, 3'b011, 1'b1);
    wait_ready(0, 1'b1, 1'b1);
    slave_xfer(0, 0, 2'b00, 0, 32'h33334444, 1'b0);
    wait_ready(1, 1'b1, 1'b1);
    slave_xfer(0, 0, 2'b00, 1, 32'h55556666, 1'b0);
    tick();

    $display("[TB] address above MAX_ADDRESS");
`ifdef AXI4LITE_WR_ADDR_CHECK_EN
    apply_request(0, 32'h100, 32'hFEEDFACE, 4'hF, 3'b000, 1'b0);
    wait_ready(0, 1'b1, 1'b0);
    exp_rsp.push_back('{req: 0, resp: 2'b11});
    tick();
    check_output("decerr_no_aw", 64'(awvalid), 64'(0));
    check_output("decerr_no_w", 64'(wvalid), 64'(0));
    check_output("decerr_bready", 64'(bready), 64'(0));
    check_output("decerr_rsp_valid", 64'(rsp_valid), 64'(2'b01));
    check_output("decerr_rsp_code", 64'(rsp_bresp), 64'(2'b11));
`else
    apply_request(0, 32'h100, 32'hFEEDFACE, 4'hF, 3'b000, 1'b1);
    wait_ready(0, 1'b1, 1'b1);
    slave_xfer(0, 0, 2'b00, 0, 32'hFEEDFACE, 1'b0);
`endif
    tick();
    tick();

    check_output("scoreboard_drained", 64'(exp_grant.size() + exp_aw.size() + exp_w.size() + exp_rsp.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
